// File: rtl/wb_output_select_buf.sv
// Writeback output selector: captures one of NUM_SRC sources into p_o with a
// one-cycle flag, and streams every capture through a show-ahead valid/ready FIFO.

module wb_src_gate #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2,
    parameter int CODE   = 1
) (
    input  logic [SEL_W-1:0]  code,
    input  logic [DATA_W-1:0] src,
    output logic [DATA_W-1:0] gated
);
    assign gated = (code == SEL_W'(CODE)) ? src : '0;
endmodule

module wb_output_select_buf #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 8,
    localparam int SEL_W  = $clog2(NUM_SRC + 1),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          control_signal,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]         p_o,
    output logic                      flag,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          fifo_count,
    output logic                      ovf,
    output logic [7:0]                drop_cnt,
    output logic                      sel_err,
    input  logic                      status_clr
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int STAGES = 1;

    logic [NUM_SRC-1:0][DATA_W-1:0] src_gated;
    logic [DATA_W-1:0]              sel_word;
    logic                           capture;
    logic                           illegal;
    logic                           full;
    logic                           pop;
    logic                           push_ok;
    logic                           drop;
    logic [STAGES:0]                vld_pipe;
    logic [STAGES:1]                vld_q;
    logic [DATA_W-1:0]              mem [DEPTH];
    logic [PTR_W-1:0]               rptr;
    logic [PTR_W-1:0]               wptr;

    // Each source is gated by its own code; at most one gate is open, so OR-merge.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_src_gate #(
            .DATA_W(DATA_W),
            .SEL_W (SEL_W),
            .CODE  (g + 1)
        ) u_gate (
            .code (control_signal),
            .src  (src_data[g*DATA_W +: DATA_W]),
            .gated(src_gated[g])
        );
    end

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_SRC; k++)
            sel_word = sel_word | src_gated[k];
    end

    assign illegal = control_signal > SEL_W'(NUM_SRC);
    assign capture = (control_signal != '0) && !illegal;

    assign full    = fifo_count == CNT_W'(DEPTH);
    assign pop     = out_valid && out_ready;
    // A full FIFO still takes the word if the head leaves on the same edge.
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign vld_pipe = {vld_q, capture};
    assign flag     = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            p_o   <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (capture)
                p_o <= sel_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= sel_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr       <= '0;
            wptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid = fifo_count != '0;
    assign out_data  = out_valid ? mem[rptr] : '0;

    // A new event on the clearing cycle takes priority over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
            sel_err  <= 1'b0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
                if (status_clr)
                    drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (status_clr) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
            if (illegal)
                sel_err <= 1'b1;
            else if (status_clr)
                sel_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_output_select_buf.sv
// Scoreboard bench for wb_output_select_buf: directed scenarios plus random traffic
// checked against a queue-based reference model.

module tb_wb_output_select_buf;
    localparam int DW = 32;
    localparam int NS = 2;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    control_signal = '0;
    logic [63:0]   src_data = '0;
    logic [31:0]   p_o;
    logic          flag;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_ready = 1'b0;
    logic [3:0]    fifo_count;
    logic          ovf;
    logic [7:0]    drop_cnt;
    logic          sel_err;
    logic          status_clr = 1'b0;

    wb_output_select_buf #(.DATA_W(DW), .NUM_SRC(NS), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .control_signal(control_signal),
        .src_data(src_data), .p_o(p_o), .flag(flag), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .fifo_count(fifo_count),
        .ovf(ovf), .drop_cnt(drop_cnt), .sel_err(sel_err), .status_clr(status_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] sb_q[$];
    logic [31:0] exp_p;
    logic        exp_flag;
    logic        exp_ovf;
    int          exp_dcnt;
    logic        exp_serr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT offers a word that will be taken, compare with the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("mon_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
                if (!out_valid)
                    chk("mon_empty_data", {32'd0, out_data}, 64'd0);
                else if (out_ready && sb_q.size() != 0)
                    chk("mon_data", {32'd0, out_data}, {32'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic step(input logic [1:0] code, input logic [31:0] s0, input logic [31:0] s1,
                        input logic rdy, input logic clr);
        bit          was_full;
        bit          popped;
        logic [31:0] w;
        control_signal = code;
        src_data       = {s1, s0};
        out_ready      = rdy;
        status_clr     = clr;
        @(posedge clk);
        was_full = (mq.size() == DP);
        popped   = (mq.size() > 0) && rdy;
        if (popped)
            void'(mq.pop_front());
        if (clr) begin
            exp_ovf  = 1'b0;
            exp_dcnt = 0;
            exp_serr = 1'b0;
        end
        if (code >= 1 && code <= NS) begin
            w        = (code == 1) ? s0 : s1;
            exp_p    = w;
            exp_flag = 1'b1;
            if (!was_full || popped) begin
                mq.push_back(w);
                sb_q.push_back(w);
            end else begin
                exp_ovf = 1'b1;
                if (exp_dcnt < 255)
                    exp_dcnt++;
            end
        end else begin
            exp_flag = 1'b0;
            if (code > NS)
                exp_serr = 1'b1;
        end
        #1;
        chk("p_o", {32'd0, p_o}, {32'd0, exp_p});
        chk("flag", {63'd0, flag}, {63'd0, exp_flag});
        chk("fifo_count", {60'd0, fifo_count}, 64'(mq.size()));
        chk("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
        chk("drop_cnt", {56'd0, drop_cnt}, 64'(exp_dcnt));
        chk("sel_err", {63'd0, sel_err}, {63'd0, exp_serr});
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        reset          = 1'b1;
        control_signal = '0;
        out_ready      = 1'b0;
        status_clr     = 1'b0;
        mq.delete();
        sb_q.delete();
        exp_p = '0; exp_flag = 1'b0; exp_ovf = 1'b0; exp_dcnt = 0; exp_serr = 1'b0;
        #1;
        chk("rst_p_o", {32'd0, p_o}, 64'd0);
        chk("rst_flag", {63'd0, flag}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_fifo_count", {60'd0, fifo_count}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
        chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DP && mq.size() > 0; i++)
            step(2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_data", {32'd0, out_data}, 64'd0);
        chk("drain_sb", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        // Reset and basic capture
        do_reset();
        step(2'd1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        chk("basic_p_o", {32'd0, p_o}, 64'hDEADBEEF);
        chk("basic_flag", {63'd0, flag}, 64'd1);
        chk("basic_out_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_out_data", {32'd0, out_data}, 64'hDEADBEEF);
        chk("basic_count", {60'd0, fifo_count}, 64'd1);
        step(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("hold_flag", {63'd0, flag}, 64'd0);
        chk("hold_p_o", {32'd0, p_o}, 64'hDEADBEEF);

        // Source select with an illegal code at the end
        do_reset();
        step(2'd2, 32'h11, 32'h22, 1'b0, 1'b0);
        chk("sel_p_o_2", {32'd0, p_o}, 64'h22);
        step(2'd1, 32'h11, 32'h22, 1'b0, 1'b0);
        chk("sel_p_o_1", {32'd0, p_o}, 64'h11);
        step(2'd0, 32'h11, 32'h22, 1'b0, 1'b0);
        step(2'd3, 32'h11, 32'h22, 1'b0, 1'b0);
        chk("sel_p_o_3", {32'd0, p_o}, 64'h11);
        chk("sel_err_set", {63'd0, sel_err}, 64'd1);
        chk("sel_count", {60'd0, fifo_count}, 64'd2);
        drain();

        // Fill and overflow
        do_reset();
        for (int v = 1; v <= 10; v++)
            step(2'd1, 32'(v), 32'h0, 1'b0, 1'b0);
        chk("ovf_count", {60'd0, fifo_count}, 64'd8);
        chk("ovf_flag", {63'd0, ovf}, 64'd1);
        chk("ovf_drops", {56'd0, drop_cnt}, 64'd2);
        chk("ovf_p_o", {32'd0, p_o}, 64'd10);
        drain();

        // Full with simultaneous pop
        do_reset();
        for (int v = 1; v <= 8; v++)
            step(2'd1, 32'(v), 32'h0, 1'b0, 1'b0);
        step(2'd1, 32'h99, 32'h0, 1'b1, 1'b0);
        chk("fullpop_count", {60'd0, fifo_count}, 64'd8);
        chk("fullpop_ovf", {63'd0, ovf}, 64'd0);
        chk("fullpop_head", {32'd0, out_data}, 64'd2);
        drain();

        // Wrap-around streaming
        do_reset();
        for (int v = 0; v < 40; v++) begin
            step(2'd2, 32'h0, 32'h1000 + 32'(v), 1'b1, 1'b0);
            chk("stream_count_le1", {63'd0, fifo_count <= 4'd1}, 64'd1);
        end
        drain();

        // Status clear racing a drop, then reset with entries queued
        do_reset();
        for (int v = 1; v <= 9; v++)
            step(2'd1, 32'(v), 32'h0, 1'b0, 1'b0);
        step(2'd1, 32'hBB, 32'h0, 1'b0, 1'b1);
        chk("clr_drop_ovf", {63'd0, ovf}, 64'd1);
        chk("clr_drop_cnt", {56'd0, drop_cnt}, 64'd1);
        do_reset();
        for (int v = 1; v <= 5; v++)
            step(2'd1, 32'(v), 32'h0, 1'b0, 1'b0);
        do_reset();

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
